regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-read-port integer register file for the RV32I core, replacing the fixed two-read/one-write `RegFile`. It provides synchronous writeback, combinational reads on `NRD` ports, hardwired-zero register 0, and a per-register pending-write scoreboard. The decode stage uses the scoreboard to detect RAW hazards against in-flight instructions. It sits between decode (read/issue) and writeback (write/retire).

## Interface
- `XLEN`, 32: register data width.
- `NREG`, 32: number of architectural registers, power of two, ≥2.
- `NRD`, 2: number of read ports, 1..4.
- `AW`, `$clog2(NREG)`: address width (derived; not overridden).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `ReadAddr`  in  `NRD*AW`  read addresses; port k at bits `[k*AW +: AW]`.
- `Data`  out  `NRD*XLEN`  read data; port k at bits `[k*XLEN +: XLEN]`.
- `Busy`  out  `NRD`  bit k = register at `ReadAddr` port k has a pending write.
- `WriteAddr`  in  `AW`  writeback destination.
- `WriteData`  in  `XLEN`  writeback value.
- `wr_en`  in  1  writeback strobe; also retires the pending write to `WriteAddr`.
- `IssueAddr`  in  `AW`  destination of the instruction leaving decode.
- `issue_en`  in  1  marks `IssueAddr` pending.

## Operation
- Storage: `NREG` x `XLEN` registers plus an `NREG`-bit `pend` vector.
- Reset: when `reset`=0 at a rising edge, all registers and all `pend` bits are cleared. Reset has priority over `wr_en` and `issue_en` in the same cycle.
- Write: at a rising edge with `wr_en`=1 and `WriteAddr`≠0, `regs[WriteAddr]` ← `WriteData` and `pend[WriteAddr]` ← 0.
- Issue: at a rising edge with `issue_en`=1 and `IssueAddr`≠0, `pend[IssueAddr]` ← 1.
- Same-edge write and issue to the same address: the data is written and `pend` ends at 1, because the issue is newer.
- Register 0: writes and issues to it are ignored. `Data` for address 0 is always 0. `Busy` for address 0 is always 0.
- Read: `Data` port k = `regs[ReadAddr_k]`, combinational, independent per port. Any number of ports may address the same register.
- Busy: `Busy[k]` = `pend[ReadAddr_k]`, subject to the bypass rule in Configuration.
- A `wr_en` to a register that is not pending is legal; it writes normally.
- Arithmetic: none. Addresses are used modulo `NREG` via the `AW` width. There is no out-of-range case.

## Timing
- Write latency: a value written at edge N is visible on `Data` after edge N, without bypass.
- Issue latency: `pend` is set at edge N, so `Busy` asserts after edge N.
- Read latency: zero cycles (combinational from `ReadAddr` and state).
- Reset values, held while `reset`=0 and after release:
  - `Data` = 0 on all ports.
  - `Busy` = 0 on all ports.
- After `reset` returns to 1, the first write takes effect at the next rising edge.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined:
  - A port whose `ReadAddr_k` equals `WriteAddr`, with `wr_en`=1 and `WriteAddr`≠0, returns `WriteData` combinationally in that same cycle.
  - That port also drives `Busy[k]`=0, unless `issue_en`=1 with `IssueAddr`=`WriteAddr` in the same cycle, in which case `Busy[k]`=1.
  - Supports write-then-read in one cycle for a single-cycle core.
- Undefined:
  - The port returns the stored (old) value.
  - `Busy[k]` reflects `pend` only.
  - The new value is visible from the next cycle.
- No other behaviour differs.

## Test plan
- Reset: drive `reset`=0 for 2 cycles after writing 0xDEAD to x5. Then read x5 on every port -> `Data`=0, `Busy`=0.
- Write/read, multi-port (`NRD`=3): write 20→x1, 30→x2, 40→x3 on consecutive edges. Set `ReadAddr`={x3,x2,x1} -> `Data`={40,30,20}. Reading x2 on all 3 ports -> 30 on each.
- x0: `wr_en`=1, `WriteAddr`=0, `WriteData`=0xFFFFFFFF, plus `issue_en` to x0 -> `Data` for x0 = 0 and `Busy` = 0 on the next cycle.
- Scoreboard: issue x7 at edge 1 -> `Busy`=1 for x7 from edge 1. Write 0x55 to x7 at edge 3 -> `Busy`=0 and `Data`=0x55 after edge 3. Issue and write x7 on the same edge -> `Busy` stays 1 and `Data`=new value.
- Bypass: write 0x1234 to x4 while `ReadAddr`=x4, holding old value 0x10.
  - With `REGFILE_BYPASS_EN`: `Data`=0x1234 in that cycle.
  - Without it: `Data`=0x10 in that cycle and 0x1234 next cycle.
- Reset mid-operation: issue x9 and write x9 with `reset`=0 on the same edge -> x9=0 and `Busy`=0 afterwards.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port integer register file with a pending-write
// scoreboard for RAW hazard detection at decode.
//   - NRD combinational read ports, one synchronous writeback port.
//   - x0 reads as zero and is never busy; writes and issues to x0 are dropped.
//   - Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data
//     (and the resulting busy state) to matching read ports.

// One read lane: selects stored data/pend for its address, applies the
// x0 rule and, when enabled, the writeback bypass.
module regfile_mp_rdport #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic [NREG-1:0][XLEN-1:0] regs,
  input  logic [NREG-1:0]           pend,
  input  logic [AW-1:0]             addr,
`ifdef REGFILE_BYPASS_EN
  input  logic                      wr_en,
  input  logic [AW-1:0]             waddr,
  input  logic [XLEN-1:0]           wdata,
  input  logic                      issue_en,
  input  logic [AW-1:0]             iaddr,
`endif
  output logic [XLEN-1:0]           data,
  output logic                      busy
);

`ifdef REGFILE_BYPASS_EN
  logic hit;
  // a write landing on this address this cycle wins over the stored copy
  assign hit = wr_en && (waddr != '0) && (addr == waddr);
`endif

  // read mux; x0 is forced to zero so it never depends on storage state
  always_comb begin
    data = regs[addr];
    busy = pend[addr];
`ifdef REGFILE_BYPASS_EN
    if (hit) begin
      data = wdata;
      // the retiring write clears pend unless a newer issue re-arms it
      busy = issue_en && (iaddr == waddr);
    end
`endif
    if (addr == '0) begin
      data = '0;
      busy = 1'b0;
    end
  end

endmodule

module regfile_mp #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   ReadAddr,
  output logic [NRD*XLEN-1:0] Data,
  output logic [NRD-1:0]      Busy,
  input  logic [AW-1:0]       WriteAddr,
  input  logic [XLEN-1:0]     WriteData,
  input  logic                wr_en,
  input  logic [AW-1:0]       IssueAddr,
  input  logic                issue_en
);

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           pend;

  logic wr_ok, iss_ok;
  assign wr_ok  = wr_en    && (WriteAddr != '0);
  assign iss_ok = issue_en && (IssueAddr != '0);

  // writeback and scoreboard update; issue is applied last so a same-edge
  // issue to the written register leaves it pending (issue is newer)
  always_ff @(posedge clk) begin
    if (!reset) begin
      regs <= '0;
      pend <= '0;
    end else begin
      if (wr_ok) begin
        regs[WriteAddr] <= WriteData;
        pend[WriteAddr] <= 1'b0;
      end
      if (iss_ok) pend[IssueAddr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_mp_rdport #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rd (
      .regs     (regs),
      .pend     (pend),
      .addr     (ReadAddr[k*AW +: AW]),
`ifdef REGFILE_BYPASS_EN
      .wr_en    (wr_en),
      .waddr    (WriteAddr),
      .wdata    (WriteData),
      .issue_en (issue_en),
      .iaddr    (IssueAddr),
`endif
      .data     (Data[k*XLEN +: XLEN]),
      .busy     (Busy[k])
    );
  end

endmodule
